// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// sequencing each access through issue/wait/response with round-robin arbitration.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // The WAIT phase lasts MEM_LATENCY cycles, counted down to zero.
  localparam logic [3:0] WAIT_LOAD = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);
  localparam bit         COMB_MEM  = (MEM_LATENCY == 0);

  state_t     state;
  logic       owner_data;
  logic       last_grant_data;
  logic       write_op;
  logic [3:0] wait_cnt;
  logic       grant_data;

  // On a tie the requester that was not granted last wins.
  assign grant_data = d_req & (~if_req | ~last_grant_data);
  assign busy       = (state != IDLE);
  assign if_stall   = if_req & ~if_ready;
  assign d_stall    = d_req & ~d_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      owner_data      <= 1'b0;
      last_grant_data <= 1'b1;
      write_op        <= 1'b0;
      wait_cnt        <= 4'd0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      if_ready        <= 1'b0;
      d_ready         <= 1'b0;
      if_rdata        <= '0;
      d_rdata         <= '0;
    end else begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner_data      <= grant_data;
            last_grant_data <= grant_data;
            write_op        <= grant_data & d_we;
            mem_addr        <= grant_data ? d_addr : if_addr;
            if (grant_data) mem_wdata <= d_wdata;
            mem_en          <= 1'b1;
            mem_we          <= grant_data & d_we;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (write_op) begin
            d_ready <= 1'b1;
            state   <= RESP;
          end else if (COMB_MEM) begin
            if (owner_data) begin
              d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (owner_data) begin
              d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ready <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: two instances (latency 0 and 3) driven by directed
// and random requesters, checked each cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit done_flag [2];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Power-up memory contents; word 1 holds a known instruction.
  function automatic logic [31:0] initWord(input int i);
    return (i == 1) ? 32'h00500093 : 32'h10000000 + 32'(i) * 32'h00010003;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int LAT = 3 * k;

    logic        reset, if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_ready, if_stall, d_ready, d_stall, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory environment: read data is only valid exactly LAT cycles after the issue cycle.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    int cyc = 0;
    int issue_cyc = -100;

    initial begin
      for (int i = 0; i < 256; i++) begin
        mem[i]     = initWord(i);
        ref_mem[i] = initWord(i);
      end
    end

    always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_en) issue_cyc <= cyc;
    end

    assign mem_rdata = (((mem_en ? cyc : issue_cyc) + LAT) == cyc) ? mem[mem_addr[9:2]] : 32'hBADC0DE0;

    // Transaction model: a grant at the end of cycle t fixes the issue cycle (t+1)
    // and the response cycle; every expected output follows from those two numbers.
    bit          m_valid = 0, m_act = 0, m_own_d = 0, m_we = 0, m_last_d = 1;
    int          m_start = -10, m_end = -10;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;

    always @(posedge clk) begin
      if (m_act && m_we && cyc == m_start) ref_mem[m_addr[9:2]] = m_wdata;
      if (reset) begin
        m_valid = 1; m_act = 0; m_last_d = 1;
        m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0;
        m_start = -10; m_end = -10;
      end else if (m_valid) begin
        if (m_act && !m_we && cyc == m_start + LAT) begin
          if (m_own_d) m_d_rdata = ref_mem[m_addr[9:2]];
          else         m_if_rdata = ref_mem[m_addr[9:2]];
        end
        if (m_act) begin
          if (cyc == m_end) m_act = 0;
        end else if (if_req || d_req) begin
          m_own_d  = d_req && (!if_req || !m_last_d);
          m_last_d = m_own_d;
          m_act    = 1;
          m_addr   = m_own_d ? d_addr : if_addr;
          m_we     = m_own_d && d_we;
          if (m_own_d) m_wdata = d_wdata;
          m_start  = cyc + 1;
          m_end    = m_we ? m_start + 1 : m_start + LAT + 1;
        end
      end
    end

    always @(negedge clk) begin
      if (m_valid) begin
        bit e_en, e_we, e_ifr, e_dr;
        e_en  = m_act && cyc == m_start;
        e_we  = e_en && m_we;
        e_ifr = m_act && cyc == m_end && !m_own_d;
        e_dr  = m_act && cyc == m_end && m_own_d;
        checkOutput($sformatf("L%0d busy", LAT), busy, m_act);
        checkOutput($sformatf("L%0d mem_en", LAT), mem_en, e_en);
        checkOutput($sformatf("L%0d mem_we", LAT), mem_we, e_we);
        checkOutput($sformatf("L%0d if_ready", LAT), if_ready, e_ifr);
        checkOutput($sformatf("L%0d d_ready", LAT), d_ready, e_dr);
        checkOutput($sformatf("L%0d if_stall", LAT), if_stall, if_req & !e_ifr);
        checkOutput($sformatf("L%0d d_stall", LAT), d_stall, d_req & !e_dr);
        checkOutput($sformatf("L%0d mem_addr", LAT), mem_addr, m_addr);
        checkOutput($sformatf("L%0d if_rdata", LAT), if_rdata, m_if_rdata);
        checkOutput($sformatf("L%0d d_rdata", LAT), d_rdata, m_d_rdata);
        if (e_we) checkOutput($sformatf("L%0d mem_wdata", LAT), mem_wdata, m_wdata);
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic applyStimulus(input bit rst, input bit ir, input logic [31:0] ia,
                                 input bit dr, input bit dwe, input logic [31:0] da,
                                 input logic [31:0] dwd);
      reset = rst; if_req = ir; if_addr = ia;
      d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    endtask

    // Call in the request cycle; returns at the negedge of the ready cycle, n cycles later.
    task automatic waitReady(input bit fetch, output int n);
      n = 0;
      forever begin
        @(negedge clk);
        if (fetch ? if_ready : d_ready) return;
        if (n >= 40) begin
          checkOutput($sformatf("L%0d ready timeout", LAT), 32'd0, 32'd1);
          return;
        end
        step();
        n++;
      end
    endtask

    initial begin
      int n, c, idx, wes;
      int rc [3];
      int ord [$];
      bit ir, dr, reraised;

      // Single fetch from 0x4 straight out of reset.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      step(); step();
      applyStimulus(0, 1, 32'h4, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput($sformatf("L%0d t1 stall c0", LAT), if_stall, 1);
      step();
      @(negedge clk);
      checkOutput($sformatf("L%0d t1 mem_en c1", LAT), mem_en, 1);
      checkOutput($sformatf("L%0d t1 mem_addr c1", LAT), mem_addr, 32'h4);
      checkOutput($sformatf("L%0d t1 stall c1", LAT), if_stall, 1);
      step();
      waitReady(1, n);
      checkOutput($sformatf("L%0d t1 ready cycle", LAT), 2 + n, 2 + LAT);
      checkOutput($sformatf("L%0d t1 rdata", LAT), if_rdata, 32'h00500093);
      step();
      if_req = 0;

      // Tie right after reset: fetch, then data, then fetch again after both re-raise.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      step(); step();
      applyStimulus(0, 1, 32'h0, 1, 0, 32'h100, 0);
      c = 0; reraised = 0;
      while (ord.size() < 3 && c < 80) begin
        @(negedge clk);
        ir = if_ready; dr = d_ready;
        if (ir) ord.push_back(1);
        if (dr) ord.push_back(2);
        step();
        c++;
        if (ir) if_req = 0;
        if (dr) d_req = 0;
        if (ord.size() == 2 && !reraised) begin
          reraised = 1;
          if_req = 1; if_addr = 32'h8;
          d_req = 1; d_addr = 32'h104;
        end
      end
      while (ord.size() < 3) ord.push_back(0);
      checkOutput($sformatf("L%0d t2 first", LAT), ord[0], 1);
      checkOutput($sformatf("L%0d t2 second", LAT), ord[1], 2);
      checkOutput($sformatf("L%0d t2 third", LAT), ord[2], 1);
      waitReady(0, n);
      checkOutput($sformatf("L%0d t2 d_rdata", LAT), d_rdata, initWord(65));
      step();
      d_req = 0;

      // Data write; d_rdata keeps the last load value.
      step();
      applyStimulus(0, 0, 0, 1, 1, 32'h100, 32'hDEADBEEF);
      n = 0; wes = 0;
      forever begin
        @(negedge clk);
        if (mem_we) begin
          wes++;
          checkOutput($sformatf("L%0d t3 we addr", LAT), mem_addr, 32'h100);
          checkOutput($sformatf("L%0d t3 we data", LAT), mem_wdata, 32'hDEADBEEF);
        end
        if (d_ready || n >= 20) break;
        step();
        n++;
      end
      checkOutput($sformatf("L%0d t3 ready cycle", LAT), n, 2);
      checkOutput($sformatf("L%0d t3 we pulses", LAT), wes, 1);
      checkOutput($sformatf("L%0d t3 d_rdata kept", LAT), d_rdata, initWord(65));
      step();
      applyStimulus(0, 0, 0, 1, 0, 32'h100, 0);
      waitReady(0, n);
      checkOutput($sformatf("L%0d t3 readback", LAT), d_rdata, 32'hDEADBEEF);
      step();
      d_req = 0;

      // Fetch from 0x8 with the address changed after the grant.
      step();
      applyStimulus(0, 1, 32'h8, 0, 0, 0, 0);
      c = 0;
      forever begin
        @(negedge clk);
        if (c >= 1 && c <= 1 + LAT)
          checkOutput($sformatf("L%0d t4 addr hold", LAT), mem_addr, 32'h8);
        if (if_ready || c >= 40) break;
        step();
        c++;
        if (c == 2) if_addr = 32'hC;
      end
      checkOutput($sformatf("L%0d t4 ready cycle", LAT), c, 2 + LAT);
      checkOutput($sformatf("L%0d t4 rdata", LAT), if_rdata, initWord(2));
      step();
      if_req = 0;

      // Reset during the wait phase (issue phase when there is no wait).
      step();
      applyStimulus(0, 1, 32'h10, 0, 0, 0, 0);
      for (int i = 0; i < ((LAT > 0) ? 2 : 1); i++) step();
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      step();
      reset = 0;
      @(negedge clk);
      checkOutput($sformatf("L%0d t5 busy", LAT), busy, 0);
      checkOutput($sformatf("L%0d t5 if_ready", LAT), if_ready, 0);
      checkOutput($sformatf("L%0d t5 mem_en", LAT), mem_en, 0);
      checkOutput($sformatf("L%0d t5 mem_addr", LAT), mem_addr, 0);
      checkOutput($sformatf("L%0d t5 if_rdata", LAT), if_rdata, 0);
      for (int i = 0; i < LAT + 3; i++) step();
      applyStimulus(0, 1, 32'h4, 0, 0, 0, 0);
      waitReady(1, n);
      checkOutput($sformatf("L%0d t5 refetch cycle", LAT), n, 2 + LAT);
      checkOutput($sformatf("L%0d t5 refetch data", LAT), if_rdata, 32'h00500093);
      step();
      if_req = 0;

      // Back-to-back fetches 0x0, 0x4, 0x8 with the request held high.
      step();
      applyStimulus(0, 1, 32'h0, 0, 0, 0, 0);
      c = 0; idx = 0;
      rc[0] = 0; rc[1] = 0; rc[2] = 0;
      while (idx < 3 && c < 60) begin
        @(negedge clk);
        ir = if_ready;
        if (ir) begin
          rc[idx] = c;
          checkOutput($sformatf("L%0d t6 data%0d", LAT, idx), if_rdata, initWord(idx));
          idx++;
        end
        step();
        c++;
        if (ir) begin
          if (idx < 3) if_addr = 32'(idx * 4);
          else         if_req = 0;
        end
      end
      checkOutput($sformatf("L%0d t6 first", LAT), rc[0], 2 + LAT);
      checkOutput($sformatf("L%0d t6 gap1", LAT), rc[1] - rc[0], LAT + 3);
      checkOutput($sformatf("L%0d t6 gap2", LAT), rc[2] - rc[1], LAT + 3);

      // Random requesters obeying the hold-until-ready protocol.
      for (int i = 0; i < 1500; i++) begin
        @(negedge clk);
        ir = if_ready; dr = d_ready;
        step();
        reset = ($urandom_range(0, 199) == 0);
        if (if_req) begin
          if (ir) begin
            if_req  = $urandom_range(0, 1) == 1;
            if_addr = 32'($urandom_range(0, 255)) << 2;
          end else if ($urandom_range(0, 3) == 0) begin
            if_addr = 32'($urandom_range(0, 255)) << 2;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          if_req  = 1;
          if_addr = 32'($urandom_range(0, 255)) << 2;
        end
        if (d_req) begin
          if (dr) begin
            d_req   = $urandom_range(0, 1) == 1;
            d_we    = $urandom_range(0, 1) == 1;
            d_addr  = 32'($urandom_range(0, 255)) << 2;
            d_wdata = $urandom;
          end else if ($urandom_range(0, 3) == 0) begin
            d_addr  = 32'($urandom_range(0, 255)) << 2;
            d_wdata = $urandom;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          d_req   = 1;
          d_we    = $urandom_range(0, 1) == 1;
          d_addr  = 32'($urandom_range(0, 255)) << 2;
          d_wdata = $urandom;
        end
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (10) step();
      done_flag[k] = 1;
    end
  end

  initial begin
    int i;
    i = 0;
    while (!(done_flag[0] && done_flag[1]) && i < 20000) begin
      @(posedge clk);
      i++;
    end
    if (!(done_flag[0] && done_flag[1]))
      checkOutput("bench completion", 32'd0, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the CPU fetch stage (instruction requester) and the load/store stage (data requester). It sequences each access through a fixed-latency issue/wait/response FSM and arbitrates round-robin on simultaneous requests. It raises per-requester stall signals so fetch and memory stages hold while waiting. It sits between the CPU stages and the memory (ROM/RAM) model.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- MEM_LATENCY, 0, cycles after the issue cycle at which mem_rdata is valid (0 = combinational memory); legal 0..15
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_WIDTH  fetch address
- if_ready  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_WIDTH  fetched instruction (registered)
- if_stall  out  1  if_req & ~if_ready
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  write data
- d_ready  out  1  one-cycle pulse: access complete
- d_rdata  out  DATA_WIDTH  load data (registered)
- d_stall  out  1  d_req & ~d_ready
- mem_en  out  1  access strobe, high in ISSUE only
- mem_we  out  1  write strobe, high in ISSUE only for writes
- mem_addr  out  ADDR_WIDTH  latched address, stable from ISSUE through capture
- mem_wdata  out  DATA_WIDTH  latched write data
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if either req is high, grant one requester, latch its addr/we/wdata into owner/mem registers, and go to ISSUE. If neither is high, stay.
- Arbitration: single request wins. If both are high, the requester not granted last wins. last_grant resets to data, so the first tie after reset goes to fetch. last_grant updates on every grant.
- ISSUE: mem_en=1, mem_we=latched we.
  - Write: go to RESP.
  - Read, MEM_LATENCY=0: capture mem_rdata into the owner's rdata register, go to RESP.
  - Otherwise: load wait counter with MEM_LATENCY-1 and go to WAIT.
- WAIT: mem_en=mem_we=0, mem_addr held. Decrement the counter. When it is 0, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP: pulse the owner's ready, then go to IDLE. The non-owner's rdata is never modified. A write never modifies d_rdata.
- Requesters see ready high and drop or renew req from the next cycle. A req still high in IDLE is a new request.
- Changes on if_addr/d_addr/d_wdata after the grant are ignored until the next grant.
- Reset mid-operation: all outputs and registers return to reset values on the next edge. No ready pulse for the aborted access. No further mem_we.

## Timing
- Reset values: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, busy=0, last_grant=data.
- if_stall and d_stall are combinational.
- Request seen in IDLE in cycle t:
  - ISSUE in cycle t+1.
  - Read capture at the end of cycle t+1+MEM_LATENCY.
  - Ready in cycle t+2+MEM_LATENCY.
  - Write ready in cycle t+2.
- Next grant is possible in the cycle after RESP. Read throughput is 1 per MEM_LATENCY+3 cycles.
- A request arriving while busy waits. Its stall stays high throughout.

## Test plan
- Single fetch, MEM_LATENCY=0: memory word 0x4 = 0x00500093, if_req in cycle 0 with if_addr=0x4.
  - mem_en=1 and mem_addr=0x4 in cycle 1.
  - if_ready=1 in cycle 2 with if_rdata=0x00500093.
  - if_stall=1 in cycles 0–1.
- Simultaneous if_req and d_req (read 0x100) right after reset:
  - Fetch is served first, then data.
  - Both are re-raised: fetch is served next (alternation).
  - Each ready pulse lasts exactly one cycle.
- Data write, d_addr=0x100, d_wdata=0xDEADBEEF:
  - mem_we=1 for exactly one cycle with matching addr and data.
  - d_ready two cycles after the request.
  - d_rdata unchanged.
- MEM_LATENCY=3 fetch from 0x8:
  - mem_addr=0x8 held for cycles 1–4.
  - if_ready in cycle 5.
  - Changing if_addr to 0xC in cycle 2 does not alter mem_addr.
- Reset asserted in a WAIT cycle:
  - Next cycle: busy=0, all outputs at reset values, no ready pulse.
  - A subsequent fetch completes with normal latency.
- Back-to-back fetches 0x0, 0x4, 0x8 with MEM_LATENCY=0: ready pulses are spaced exactly 3 cycles apart and the data matches the memory contents.
